axi_dma_copy_master: RTL and testbench
======================================

Name: axi_dma_copy_master

Overview:
Single-beat AXI initiator that copies a block of memory words from a source address range to a destination address range. It drives the same AXI channel set that axi_memory_slave responds to: AW, W, B, AR and R. A word is read over AR/R, buffered, then written over AW/W/B, and the sequence repeats. It sits between the DMA register/control front end and the memory slave, and is the DMA datapath engine.

Parameters:
ADDR_WIDTH, 32, AXI address width; addresses are word indices, so each step increments by 1.
DATA_WIDTH, 64, AXI data width; a multiple of 8.
LEN_WIDTH, 16, width of the transfer word count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request; sampled only in IDLE
src_addr  input  ADDR_WIDTH  first source word address; latched on accepted start
dst_addr  input  ADDR_WIDTH  first destination word address; latched on accepted start
num_words  input  LEN_WIDTH  number of words to copy; latched on accepted start
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle pulse at completion, including error completion
error  output  1  sticky; set by a non-OKAY response; cleared by the next accepted start
words_done  output  LEN_WIDTH  count of words whose B response has completed
m_axi_awvalid  output  1  write address valid
m_axi_awready  input  1  write address ready
m_axi_awaddr  output  ADDR_WIDTH  write word address
m_axi_wvalid  output  1  write data valid
m_axi_wready  input  1  write data ready
m_axi_wdata  output  DATA_WIDTH  write data
m_axi_wstrb  output  DATA_WIDTH/8  write byte strobes; always all ones
m_axi_wlast  output  1  always 1 while wvalid is high; 0 otherwise
m_axi_bvalid  input  1  write response valid
m_axi_bready  output  1  write response ready
m_axi_bresp  input  2  write response
m_axi_arvalid  output  1  read address valid
m_axi_arready  input  1  read address ready
m_axi_araddr  output  ADDR_WIDTH  read word address
m_axi_rvalid  input  1  read data valid
m_axi_rready  output  1  read data ready
m_axi_rdata  input  DATA_WIDTH  read data
m_axi_rresp  input  2  read response
m_axi_rlast  input  1  ignored; every read is single-beat

Behaviour:
- Timing domain: all outputs are registered. Reset is synchronous to the rising edge of clk and active-high (rst).
- Reset values: every valid and ready output is 0; busy, done and error are 0; words_done is 0; all address and data outputs are 0; state is IDLE.
- Handshake rule: a channel transfer completes on a rising edge where valid and ready are both 1.
  - Once asserted, a valid stays high, with address and data stable, until its handshake edge.
  - It drops on the cycle after that edge.
  - The block never waits for ready before asserting valid.
- IDLE:
  - start=1 with num_words!=0: latch src_addr, dst_addr and num_words; clear error and words_done; set busy; go to RD_ADDR.
  - start=1 with num_words=0: go to DONE without any AXI activity, and clear error.
- RD_ADDR: arvalid=1, araddr = current source address. On the AR handshake, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On the R handshake, capture rdata into the word buffer and go to WR.
  - If rresp!=00, set error and go to DONE with no write issued.
- WR:
  - awvalid=1 and wvalid=1 are asserted together; awaddr = current destination address; wdata = word buffer.
  - Each valid drops independently after its own handshake. The two handshakes may occur in the same cycle or in either order.
  - When both have completed, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On the B handshake, increment words_done.
  - If bresp!=00: set error and go to DONE.
  - Else if words_done+1 == num_words: go to DONE.
  - Else: increment the source and destination addresses by 1, with modulo 2^ADDR_WIDTH wrap, and go to RD_ADDR.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Outstanding transactions: at most one AXI transaction is outstanding at any time; AR and AW are never active together.
- start during a transfer: a start received in any state other than IDLE is ignored and has no effect on the latched parameters.
- Reset mid-transfer:
  - All outputs return to their reset values on the next edge.
  - An in-flight beat is abandoned.
  - The responder must also be reset.
- Word count: num_words = 2^LEN_WIDTH-1 is legal; words_done must not overflow.

Test Plan:
- Reset check: assert rst with clocks running -> every output is 0 on the next edge; state is IDLE; done is never pulsed.
- Single word: memory preloaded with mem[i]=i; start with src=4, dst=20, num_words=1 -> exactly one AR with araddr=4 and one AW with awaddr=20, wdata=4, wstrb=8'hFF, wlast=1; mem[20]=4; done pulses once; words_done=1; error=0.
- Block copy: src=0, dst=100, num_words=8 -> mem[100..107]=0..7; araddr runs 0..7 and awaddr runs 100..107 in order; busy is high throughout; done arrives after the 8th B handshake.
- Zero length: num_words=0 -> done pulses within 2 cycles of start; no valid is ever asserted; error=0.
- Error injection: responder returns rresp=2'b10 on word 3 of 5 -> no AW/W for that word; error=1; words_done=2; done pulses.
- Backpressure and stray start: responder delays awready by 3 cycles after wready, and start is pulsed mid-transfer -> wvalid drops after the W handshake while awvalid holds; the copy completes correctly; the stray start has no effect.
- Mid-transfer reset: rst asserted during WR -> all valids are 0 on the next edge; a subsequent start copies correctly.

Source files
------------

// File: rtl/axi_dma_copy_master_if.sv
// Single-beat AXI channel bundle (AW, W, B, AR, R) between the DMA copy engine
// and a word-addressed memory responder.
interface axi_dma_copy_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_dma_copy_master.sv
// DMA datapath engine: copies num_words words one at a time, reading each over AR/R
// and writing it back over AW/W/B, with at most one AXI transaction in flight.
module axi_dma_copy_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    src_addr,
    input  logic [ADDR_WIDTH-1:0]    dst_addr,
    input  logic [LEN_WIDTH-1:0]     num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [LEN_WIDTH-1:0]     words_done,
    axi_dma_copy_master_if.master    m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_WR_RESP,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    words_done_q, words_done_d;
    logic                    arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    bready_q, bready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    // Reads are always single-beat, so the last flag carries no information.
    logic unused_rlast;
    assign unused_rlast = m_axi.rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            bready_q     <= bready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        bready_d     = bready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_words != '0) begin
                        src_d        = src_addr;
                        dst_d        = dst_addr;
                        len_d        = num_words;
                        words_done_d = '0;
                        busy_d       = 1'b1;
                        arvalid_d    = 1'b1;
                        araddr_d     = src_addr;
                        state_d      = S_RD_ADDR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_RD_ADDR: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (rready_q && m_axi.rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != 2'b00) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // wdata_q doubles as the word buffer between read and write.
                        wdata_d   = m_axi.rdata;
                        awaddr_d  = dst_q;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end
                end
            end

            S_WR: begin
                // AW and W complete independently; leave only once both have gone.
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (bready_q && m_axi.bvalid) begin
                    bready_d     = 1'b0;
                    words_done_d = words_done_q + LEN_ONE;
                    if (m_axi.bresp != 2'b00) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (words_done_d == len_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        src_d     = src_q + ADDR_ONE;
                        dst_d     = dst_q + ADDR_ONE;
                        arvalid_d = 1'b1;
                        araddr_d  = src_q + ADDR_ONE;
                        state_d   = S_RD_ADDR;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_done    = words_done_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wvalid_q;
    assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_dma_copy_master.sv
// Directed and randomized copies against a 256-word memory responder; expected traffic
// and memory image come from a word-by-word copy model kept in the bench.
module tb_axi_dma_copy_master;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] num_words = '0;
    logic          busy, done, error;
    logic [LW-1:0] words_done;

    always #5 clk = ~clk;

    axi_dma_copy_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi_if ();

    axi_dma_copy_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_words(num_words),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .m_axi(m_axi_if)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- memory responder ----------------
    logic [63:0] mem [256];
    logic        load_req = 1'b0;
    int unsigned fill_seed = 0;
    bit          bp_mode = 1'b0;
    int          err_rd_abs = -1;
    int          err_b_abs = -1;
    int          rd_total = 0;
    int          b_total = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    int          aw_wait = 0;
    logic [31:0] abuf = '0;
    logic [63:0] wbuf = '0;

    function automatic logic [63:0] pat(input int unsigned seed, input int unsigned i);
        if (seed == 0) return 64'(i);
        return {seed ^ (i * 32'h9E37_79B9), (i + 1) * seed + 32'h0123_4567};
    endfunction

    always @(posedge clk) begin
        if (load_req) for (int i = 0; i < 256; i++) mem[i] <= pat(fill_seed, i);
        if (rst) begin
            m_axi_if.arready <= 1'b0;
            m_axi_if.rvalid  <= 1'b0;
            m_axi_if.rdata   <= '0;
            m_axi_if.rresp   <= 2'b00;
            m_axi_if.rlast   <= 1'b0;
            m_axi_if.awready <= 1'b0;
            m_axi_if.wready  <= 1'b0;
            m_axi_if.bvalid  <= 1'b0;
            m_axi_if.bresp   <= 2'b00;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_wait <= 0;
        end else begin
            m_axi_if.arready <= ($urandom_range(0, 2) != 0) && !(m_axi_if.arvalid && m_axi_if.arready);
            if (m_axi_if.rvalid && m_axi_if.rready) m_axi_if.rvalid <= 1'b0;
            if (m_axi_if.arvalid && m_axi_if.arready) begin
                m_axi_if.rvalid <= 1'b1;
                m_axi_if.rlast  <= 1'b1;
                m_axi_if.rdata  <= mem[m_axi_if.araddr[7:0]];
                m_axi_if.rresp  <= (rd_total == err_rd_abs) ? 2'b10 : 2'b00;
                rd_total <= rd_total + 1;
            end
            if (m_axi_if.wvalid && m_axi_if.wready) begin
                w_got <= 1'b1;
                wbuf  <= m_axi_if.wdata;
            end
            if (m_axi_if.awvalid && m_axi_if.awready) begin
                aw_got <= 1'b1;
                abuf   <= m_axi_if.awaddr;
            end
            if (w_got && !aw_got) aw_wait <= aw_wait + 1;
            if (bp_mode) begin
                m_axi_if.wready  <= 1'b1;
                m_axi_if.awready <= w_got && !aw_got && (aw_wait >= 2);
            end else begin
                m_axi_if.wready  <= 1'($urandom_range(0, 1));
                m_axi_if.awready <= 1'($urandom_range(0, 1));
            end
            if (m_axi_if.bvalid && m_axi_if.bready) m_axi_if.bvalid <= 1'b0;
            if (aw_got && w_got) begin
                mem[abuf[7:0]]  <= wbuf;
                m_axi_if.bvalid <= 1'b1;
                m_axi_if.bresp  <= (b_total == err_b_abs) ? 2'b10 : 2'b00;
                b_total <= b_total + 1;
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                aw_wait <= 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic        p_rst = 1'b1;
    logic        p_arvalid = 1'b0, p_arready = 1'b0, p_awvalid = 1'b0, p_awready = 1'b0;
    logic        p_wvalid = 1'b0, p_wready = 1'b0;
    logic [31:0] p_araddr = '0, p_awaddr = '0;
    logic [63:0] p_wdata = '0;
    logic [31:0] ar_log [4096];
    logic [31:0] aw_log [4096];
    logic [63:0] w_log  [4096];
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, done_cnt = 0, viol = 0, aw_only = 0;

    always @(posedge clk) begin
        p_rst     <= rst;
        p_arvalid <= m_axi_if.arvalid;
        p_arready <= m_axi_if.arready;
        p_araddr  <= m_axi_if.araddr;
        p_awvalid <= m_axi_if.awvalid;
        p_awready <= m_axi_if.awready;
        p_awaddr  <= m_axi_if.awaddr;
        p_wvalid  <= m_axi_if.wvalid;
        p_wready  <= m_axi_if.wready;
        p_wdata   <= m_axi_if.wdata;
    end

    function automatic int proto_faults();
        int f = 0;
        if (!p_rst) begin
            if (p_arvalid && p_arready) begin
                if (m_axi_if.arvalid !== 1'b0) f++;
            end else if (p_arvalid) begin
                if (m_axi_if.arvalid !== 1'b1 || m_axi_if.araddr !== p_araddr) f++;
            end
            if (p_awvalid && p_awready) begin
                if (m_axi_if.awvalid !== 1'b0) f++;
            end else if (p_awvalid) begin
                if (m_axi_if.awvalid !== 1'b1 || m_axi_if.awaddr !== p_awaddr) f++;
            end
            if (p_wvalid && p_wready) begin
                if (m_axi_if.wvalid !== 1'b0) f++;
            end else if (p_wvalid) begin
                if (m_axi_if.wvalid !== 1'b1 || m_axi_if.wdata !== p_wdata) f++;
            end
        end
        if (m_axi_if.arvalid === 1'b1 && m_axi_if.awvalid === 1'b1) f++;
        if (m_axi_if.wlast !== m_axi_if.wvalid) f++;
        if (m_axi_if.wvalid === 1'b1 && m_axi_if.wstrb !== 8'hFF) f++;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!p_rst) begin
            if (p_arvalid && p_arready) begin
                ar_log[ar_cnt % 4096] <= p_araddr;
                ar_cnt <= ar_cnt + 1;
            end
            if (p_awvalid && p_awready) begin
                aw_log[aw_cnt % 4096] <= p_awaddr;
                aw_cnt <= aw_cnt + 1;
            end
            if (p_wvalid && p_wready) begin
                w_log[w_cnt % 4096] <= p_wdata;
                w_cnt <= w_cnt + 1;
            end
        end
        viol <= viol + proto_faults();
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (m_axi_if.awvalid === 1'b1 && m_axi_if.wvalid === 1'b0) aw_only <= aw_only + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {58'd0, m_axi_if.arvalid, m_axi_if.rready, m_axi_if.awvalid,
                              m_axi_if.wvalid, m_axi_if.bready, m_axi_if.wlast}, 64'd0);
        check({tag, "_status"}, {61'd0, busy, done, error}, 64'd0);
        check({tag, "_words_done"}, 64'(words_done), 64'd0);
        check({tag, "_addrs"}, {m_axi_if.araddr, m_axi_if.awaddr}, 64'd0);
        check({tag, "_wdata"}, m_axi_if.wdata, 64'd0);
    endtask

    task automatic load(input int unsigned seed);
        @(negedge clk);
        fill_seed = seed;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    // One copy: model the expected traffic and memory image, run it, compare.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input int err_rd, input int err_b, input bit stray);
        logic [63:0] em [256];
        logic [31:0] ear[$];
        logic [31:0] eaw[$];
        logic [63:0] ewd[$];
        int k_rd, k_wr, exp_words, mm, cycles, busy_bad, ar0, aw0, w0, d0, v0;
        bit exp_err, valid_seen;
        logic [63:0] word;

        @(negedge clk);
        #1;
        for (int i = 0; i < 256; i++) em[i] = mem[i];
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt; v0 = viol;

        if (n == 0) begin
            k_rd = 0; k_wr = 0; exp_words = -1; exp_err = 1'b0;
        end else if (err_rd >= 0 && err_rd < n) begin
            k_rd = err_rd + 1; k_wr = err_rd; exp_words = err_rd; exp_err = 1'b1;
        end else if (err_b >= 0 && err_b < n) begin
            k_rd = err_b + 1; k_wr = err_b + 1; exp_words = err_b + 1; exp_err = 1'b1;
        end else begin
            k_rd = n; k_wr = n; exp_words = n; exp_err = 1'b0;
        end
        for (int i = 0; i < k_rd; i++) ear.push_back(src + 32'(i));
        for (int i = 0; i < k_wr; i++) begin
            word = em[8'(src + 32'(i))];
            eaw.push_back(dst + 32'(i));
            ewd.push_back(word);
            em[8'(dst + 32'(i))] = word;
        end
        err_rd_abs = (err_rd >= 0) ? rd_total + err_rd : -1;
        err_b_abs  = (err_b  >= 0) ? b_total + err_b   : -1;

        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; num_words = LW'(n);
        @(negedge clk);
        start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_words = LW'($urandom);
        cycles = 1; busy_bad = 0; valid_seen = 1'b0;
        while (done !== 1'b1 && cycles < 3000) begin
            if (busy !== 1'b1) busy_bad++;
            if (m_axi_if.arvalid || m_axi_if.awvalid || m_axi_if.wvalid) valid_seen = 1'b1;
            if (stray && cycles == 8) begin
                start = 1'b1; src_addr = 32'd250; dst_addr = 32'd5; num_words = 16'd1;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        if (m_axi_if.arvalid || m_axi_if.awvalid || m_axi_if.wvalid) valid_seen = 1'b1;

        check("done_seen", 64'(done), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("busy_held", 64'(busy_bad), 64'd0);
        check("error_flag", 64'(error), 64'(exp_err));
        if (exp_words >= 0) check("words_done", 64'(words_done), 64'(exp_words));
        if (n == 0) begin
            check("zero_len_latency", 64'(cycles <= 2), 64'd1);
            check("zero_len_no_valid", 64'(valid_seen), 64'd0);
        end

        @(negedge clk);
        #1;
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("ar_count", 64'(ar_cnt - ar0), 64'(k_rd));
        check("aw_count", 64'(aw_cnt - aw0), 64'(k_wr));
        check("w_count", 64'(w_cnt - w0), 64'(k_wr));
        for (int i = 0; i < k_rd && i < ar_cnt - ar0; i++)
            check("araddr", 64'(ar_log[(ar0 + i) % 4096]), 64'(ear[i]));
        for (int i = 0; i < k_wr && i < aw_cnt - aw0; i++)
            check("awaddr", 64'(aw_log[(aw0 + i) % 4096]), 64'(eaw[i]));
        for (int i = 0; i < k_wr && i < w_cnt - w0; i++)
            check("wdata", w_log[(w0 + i) % 4096], ewd[i]);
        mm = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== em[i]) mm++;
        check("mem_image", 64'(mm), 64'd0);
        check("protocol", 64'(viol - v0), 64'd0);
        err_rd_abs = -1;
        err_b_abs  = -1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int n;
        int e;
        bit found;
        logic [31:0] s, d;

        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_no_done", 64'(done_cnt), 64'd0);
        load(0);
        rst = 1'b0;

        run_copy(32'd4, 32'd20, 1, -1, -1, 1'b0);
        check("single_mem20", mem[20], 64'd4);

        run_copy(32'd0, 32'd100, 8, -1, -1, 1'b0);
        for (int i = 0; i < 8; i++) check("block_mem", mem[100 + i], 64'(i));

        run_copy(32'd10, 32'd30, 5, 2, -1, 1'b0);
        run_copy(32'd7, 32'd50, 0, -1, -1, 1'b0);

        bp_mode = 1'b1;
        a0 = aw_only;
        run_copy(32'd60, 32'd160, 6, -1, -1, 1'b1);
        check("bp_aw_held_alone", 64'(aw_only > a0), 64'd1);
        bp_mode = 1'b0;

        load(32'hC0FFEE);
        run_copy(32'hFFFF_FFFE, 32'h0000_0010, 4, -1, -1, 1'b0);
        run_copy(32'd0, 32'd200, 4, -1, 1, 1'b0);

        // Reset while a write is in flight.
        @(negedge clk);
        start = 1'b1; src_addr = 32'd40; dst_addr = 32'd140; num_words = 16'd4;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (m_axi_if.awvalid === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst_reached_wr", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        run_copy(32'd40, 32'd140, 4, -1, -1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            load($urandom | 32'd1);
            bp_mode = ($urandom_range(0, 3) == 0);
            n = int'($urandom_range(0, 12));
            s = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
            d = $urandom;
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
            run_copy(s, d, n, e, -1, 1'($urandom_range(0, 1)));
        end
        bp_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
